// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-type encodings,
// FSM state encoding and the alignment rule used by the optional misalign check.
package dmem_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unknown type codes behave as word accesses, so they need full alignment.
  function automatic logic is_misaligned(input logic [2:0] dm_type, input logic [1:0] off);
    logic mis;
    case (dm_type)
      DM_BYTE, DM_BYTE_U: mis = 1'b0;
      DM_HALF, DM_HALF_U: mis = off[0];
      default:            mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic: store aligner (enables + replicated data)
// and load formatter (lane select + sign/zero extension).
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  i_st_type,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be   = 4'b1111;
    o_st_data = i_st_data;
    case (i_st_type)
      DM_BYTE, DM_BYTE_U: begin
        o_st_be   = 4'b0001 << i_st_off;
        o_st_data = {4{i_st_data[7:0]}};
      end
      DM_HALF, DM_HALF_U: begin
        o_st_be   = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_data = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_ld_word[7:0];
    case (i_ld_off)
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      2'd3:    w_byte = i_ld_word[31:24];
      default: w_byte = i_ld_word[7:0];
    endcase
    w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_type)
      DM_BYTE:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      DM_BYTE_U: o_ld_data = {24'h0, w_byte};
      DM_HALF:   o_ld_data = {{16{w_half[15]}}, w_half};
      DM_HALF_U: o_ld_data = {16'h0, w_half};
      default:   o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: IDLE/REQ/DONE handshake FSM with bus timeout.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses without a bus cycle.
//
// state   | meaning
// IDLE    | waiting for a core load/store; stall asserted combinationally on request
// REQ     | bus_req high, bus_* held, waiting for bus_ready or timeout
// DONE    | result valid, stall released for one cycle, core inputs ignored
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_nxt;
  logic [15:0] r_cnt;
  logic [2:0]  r_type;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_err, r_misalign;
  logic        r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;

  logic        w_acc, w_mis, w_start, w_mis_done, w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data, w_ld_data;

  assign w_acc = mem_r | mem_w;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_mis = is_misaligned(dm_type, addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  assign w_start    = (r_state == ST_IDLE) & w_acc & ~w_mis;
  assign w_mis_done = (r_state == ST_IDLE) & w_acc & w_mis;
  assign w_timeout  = (r_cnt == TO_LAST);

  dmem_lane u_lane (
    .i_st_type (dm_type),
    .i_st_off  (addr[1:0]),
    .i_st_data (wdata),
    .o_st_be   (w_st_be),
    .o_st_data (w_st_data),
    .i_ld_type (r_type),
    .i_ld_off  (r_off),
    .i_ld_word (bus_rdata),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc) w_nxt = w_mis ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus_ready || w_timeout) w_nxt = ST_DONE;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // bus_ready has priority over the timeout when both land in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 16'h0;
      r_type      <= DM_WORD;
      r_off       <= 2'b00;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
    end else if (w_start) begin
      r_cnt       <= 16'h0;
      r_type      <= dm_type;
      r_off       <= addr[1:0];
      r_err       <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_we    <= mem_w;
      r_bus_addr  <= {addr[31:2], 2'b00};
      r_bus_be    <= mem_w ? w_st_be : 4'b1111;
      r_bus_wdata <= w_st_data;
    end else if (w_mis_done) begin
      r_err      <= 1'b0;
      r_misalign <= 1'b1;
      r_rdata    <= 32'h0;
    end else if (r_state == ST_REQ) begin
      if (bus_ready) begin
        if (!r_bus_we) r_rdata <= w_ld_data;
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign stall     = ((r_state == ST_IDLE) & w_acc) | (r_state == ST_REQ);
  assign bus_req   = (r_state == ST_REQ);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT=4; expectations are hand-computed.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r = 1'b0, mem_w = 1'b0;
  logic [2:0]  dm_type = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, err, misalign;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          cyc, nreq;
  logic        done;
  logic [31:0] c_addr, c_wdata, d_rdata;
  logic [3:0]  c_be;
  logic        c_we, d_err, d_mis;

  // Runs one core access; bus_ready rises after wait_n REQ cycles.
  // cyc counts every cycle from the request cycle through DONE.
  task do_acc(input logic r, input logic w, input logic [2:0] t,
              input logic [31:0] a, input logic [31:0] wd,
              input logic [31:0] rd, input int wait_n);
    @(posedge clk); #1;
    mem_r = r; mem_w = w; dm_type = t; addr = a; wdata = wd;
    bus_rdata = rd; bus_ready = 1'b0;
    cyc = 0; nreq = 0; done = 1'b0;
    c_addr = 'x; c_wdata = 'x; c_be = 'x; c_we = 1'bx;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (!stall) done = 1'b1;
      else if (bus_req) begin
        nreq++;
        if (nreq == 1) begin
          c_addr = bus_addr; c_wdata = bus_wdata; c_be = bus_be; c_we = bus_we;
        end
        bus_ready = (nreq > wait_n);
      end
    end
    check("done_reached", 32'(done), 32'd1);
    d_rdata = rdata; d_err = err; d_mis = misalign;
    @(posedge clk); #1;
    mem_r = 1'b0; mem_w = 1'b0; bus_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // sw, ready immediately
    do_acc(1'b0, 1'b1, DM_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    check("sw_cycles", 32'(cyc), 32'd3);
    check("sw_nreq", 32'(nreq), 32'd1);
    check("sw_addr", c_addr, 32'h10);
    check("sw_be", 32'(c_be), 32'hF);
    check("sw_wdata", c_wdata, 32'hDEADBEEF);
    check("sw_we", 32'(c_we), 32'd1);

    do_acc(1'b0, 1'b1, DM_BYTE, 32'h13, 32'h000000A5, 32'h0, 0);
    check("sb_be", 32'(c_be), 32'h8);
    check("sb_wdata", c_wdata, 32'hA5A5A5A5);
    check("sb_addr", c_addr, 32'h10);

    do_acc(1'b0, 1'b1, DM_HALF, 32'h22, 32'h1234ABCD, 32'h0, 0);
    check("sh_be", 32'(c_be), 32'hC);
    check("sh_wdata", c_wdata, 32'hABCDABCD);

    do_acc(1'b1, 1'b0, DM_BYTE, 32'h22, 32'h0, 32'h80F17F02, 0);
    check("lb_rdata", d_rdata, 32'hFFFFFFF1);
    check("lb_be", 32'(c_be), 32'hF);
    check("lb_we", 32'(c_we), 32'd0);
    do_acc(1'b1, 1'b0, DM_BYTE_U, 32'h22, 32'h0, 32'h80F17F02, 0);
    check("lbu_rdata", d_rdata, 32'h000000F1);
    do_acc(1'b1, 1'b0, DM_HALF, 32'h22, 32'h0, 32'h80F17F02, 0);
    check("lh_rdata", d_rdata, 32'hFFFF80F1);
    do_acc(1'b1, 1'b0, DM_HALF_U, 32'h22, 32'h0, 32'h80F17F02, 0);
    check("lhu_rdata", d_rdata, 32'h000080F1);
    do_acc(1'b1, 1'b0, DM_BYTE, 32'h21, 32'h0, 32'h80F17F02, 0);
    check("lb_pos_rdata", d_rdata, 32'h0000007F);

    // lw with two wait cycles
    do_acc(1'b1, 1'b0, DM_WORD, 32'h20, 32'h0, 32'h80F17F02, 2);
    check("lw_wait_cycles", 32'(cyc), 32'd5);
    check("lw_wait_rdata", d_rdata, 32'h80F17F02);
    check("lw_wait_err", 32'(d_err), 32'd0);

    // lw timeout
    do_acc(1'b1, 1'b0, DM_WORD, 32'h24, 32'h0, 32'h55555555, 100);
    check("to_cycles", 32'(cyc), 32'd6);
    check("to_nreq", 32'(nreq), 32'd4);
    check("to_err", 32'(d_err), 32'd1);
    check("to_rdata", d_rdata, 32'h0);
    do_acc(1'b0, 1'b1, DM_WORD, 32'h28, 32'h01020304, 32'h0, 0);
    check("after_to_err", 32'(d_err), 32'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
    do_acc(1'b1, 1'b0, DM_HALF, 32'h21, 32'h0, 32'h80F17F02, 0);
    check("mis_lh_cycles", 32'(cyc), 32'd2);
    check("mis_lh_nreq", 32'(nreq), 32'd0);
    check("mis_lh_flag", 32'(d_mis), 32'd1);
    check("mis_lh_rdata", d_rdata, 32'h0);
    do_acc(1'b0, 1'b1, DM_WORD, 32'h2A, 32'h0, 32'h0, 0);
    check("mis_sw_nreq", 32'(nreq), 32'd0);
    check("mis_sw_flag", 32'(d_mis), 32'd1);
    do_acc(1'b0, 1'b1, DM_WORD, 32'h2C, 32'h0, 32'h0, 0);
    check("mis_clear", 32'(d_mis), 32'd0);
`else
    do_acc(1'b1, 1'b0, DM_HALF, 32'h21, 32'h0, 32'h80F17F02, 0);
    check("lh21_cycles", 32'(cyc), 32'd3);
    check("lh21_rdata", d_rdata, 32'h00007F02);
    check("lh21_flag", 32'(d_mis), 32'd0);
    do_acc(1'b0, 1'b1, DM_HALF, 32'h21, 32'h0000BEEF, 32'h0, 0);
    check("sh21_be", 32'(c_be), 32'h3);
    check("sh21_wdata", c_wdata, 32'hBEEFBEEF);
`endif

    // reset while in REQ
    @(posedge clk); #1;
    mem_r = 1'b1; dm_type = DM_WORD; addr = 32'h30; bus_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_bus_req", 32'(bus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_bus_req", 32'(bus_req), 32'd0);
    check("async_rst_bus_addr", bus_addr, 32'h0);
    mem_r = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    do_acc(1'b1, 1'b1, DM_WORD, 32'h40, 32'h11223344, 32'h0, 0);
    check("rw_cycles", 32'(cyc), 32'd3);
    check("rw_we", 32'(c_we), 32'd1);
    check("rw_be", 32'(c_be), 32'hF);
    check("rw_wdata", c_wdata, 32'h11223344);
    check("rw_addr", c_addr, 32'h40);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
